// File: rtl/red_pitaya_sys_master_pkg.sv
// Shared definitions for the system-bus master: FSM states, command record
// layout and the default transaction timeout.
package red_pitaya_sys_master_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 1023;
  localparam int unsigned CMD_W           = 69;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } cmd_t;

endpackage

// File: rtl/red_pitaya_sys_master_if.sv
// Command, response and system-bus signals of the bus master, grouped so the
// master and its environment connect through one port.
interface red_pitaya_sys_master_if;

  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_sel_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_tmo_o;

  logic [31:0] sys_addr_o;
  logic [31:0] sys_wdata_o;
  logic [3:0]  sys_sel_o;
  logic        sys_wen_o;
  logic        sys_ren_o;
  logic [31:0] sys_rdata_i;
  logic        sys_err_i;
  logic        sys_ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o,
    input  rsp_ready_i,
    output sys_addr_o, sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o,
    input  sys_rdata_i, sys_err_i, sys_ack_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o,
    output rsp_ready_i,
    input  sys_addr_o, sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o,
    output sys_rdata_i, sys_err_i, sys_ack_i
  );

endinterface

// File: rtl/red_pitaya_sys_cmd_fifo.sv
// Single-clock command FIFO, DEPTH x cmd_t, with head exposed combinationally.
module red_pitaya_sys_cmd_fifo
  import red_pitaya_sys_master_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic push_i,
  input  cmd_t data_i,
  input  logic pop_i,
  output cmd_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  cmd_t        mem_q [DEPTH];
  cmd_t        mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) begin
      mem_d[wr_ptr_q[AW-1:0]] = data_i;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/red_pitaya_sys_master.sv
// Queued system-bus master: buffers commands, runs one bus transaction at a
// time with a timeout, and returns an in-order response per command.
module red_pitaya_sys_master
  import red_pitaya_sys_master_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  red_pitaya_sys_master_if.master         bus,
  output logic                            busy_o
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  cmd_t        cmd_in;
  cmd_t        head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  logic        rdy_q;
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        wen_q, wen_d;
  logic        ren_q, ren_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;

  assign cmd_in = '{we: bus.cmd_we_i, addr: bus.cmd_addr_i,
                    wdata: bus.cmd_wdata_i, sel: bus.cmd_sel_i};

  // rdy_q keeps cmd_ready_o low through reset and for the release cycle.
  assign bus.cmd_ready_o = rdy_q && !fifo_full;
  assign push            = bus.cmd_valid_i && bus.cmd_ready_o;
  assign pop             = (state_q == ST_IDLE) && !fifo_empty;

  red_pitaya_sys_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .data_i  (cmd_in),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    we_d        = we_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          addr_d  = head.addr;
          wdata_d = head.wdata;
          sel_d   = head.sel;
          we_d    = head.we;
          wen_d   = head.we;
          ren_d   = !head.we;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Ack/err is checked first so it wins over a same-cycle timeout.
        if (bus.sys_ack_i || bus.sys_err_i) begin
          rdata_d     = we_q ? '0 : bus.sys_rdata_i;
          err_d       = bus.sys_err_i;
          tmo_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_inc == TMO_LIMIT) begin
          rdata_d     = '0;
          err_d       = 1'b1;
          tmo_d       = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdy_q       <= 1'b0;
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      rdy_q       <= 1'b1;
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.sys_addr_o  = addr_q;
  assign bus.sys_wdata_o = wdata_q;
  assign bus.sys_sel_o   = sel_q;
  assign bus.sys_wen_o   = wen_q;
  assign bus.sys_ren_o   = ren_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
  assign bus.rsp_tmo_o   = tmo_q;
  assign busy_o          = (state_q != ST_IDLE) || !fifo_empty;

endmodule
